// File: rtl/frame_signature.sv
// Frame signature generator: CRC-16/CCITT over the visible pixels of each
// complete frame, with line/frame timing checks against the nominal raster.
module frame_signature #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int HTOTAL     = 800,
    parameter int VTOTAL     = 525,
    parameter int PIX_OFFSET = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [5:0]  rrggbb_i,
    input  logic        next_vertical_i,
    input  logic        next_frame_i,
    output logic [15:0] sig_o,
    output logic        sig_valid_o,
    output logic [7:0]  frame_cnt_o,
    output logic        sync_err_o
);

    localparam int HW = (HTOTAL > 1) ? $clog2(HTOTAL) : 1;
    localparam int VW = $clog2(VTOTAL + 1) + 1;
    localparam logic [HW-1:0] HMAX   = HW'(HTOTAL - 1);
    localparam logic [31:0]   PIX_LO = 32'(PIX_OFFSET);
    localparam logic [31:0]   PIX_HI = 32'(PIX_OFFSET + WIDTH);
    localparam logic [31:0]   V_VIS  = 32'(HEIGHT);
    localparam logic [31:0]   V_TOT  = 32'(VTOTAL);
    localparam logic [15:0]   CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [15:0]     crc_q, crc_d;
    logic [15:0]     sig_q, sig_d;
    logic            sig_valid_q, sig_valid_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            sync_err_q, sync_err_d;
    logic            visible;
    logic            timing_err;

    // Shifts one 6-bit pixel into the CRC, MSB first.
    function automatic logic [15:0] crc_absorb6(input logic [15:0] crc, input logic [5:0] pix);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 5; i >= 0; i--) begin
            fb = c[15] ^ pix[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (next_vertical_i)     hcnt_d = '0;
        else if (hcnt_q != HMAX) hcnt_d = hcnt_q + 1'b1;

        if (next_frame_i)                         vcnt_d = '0;
        else if (next_vertical_i && vcnt_q != '1) vcnt_d = vcnt_q + 1'b1;

        visible = (32'(hcnt_q) >= PIX_LO) && (32'(hcnt_q) < PIX_HI) && (32'(vcnt_q) < V_VIS);

        // The frame pulse itself closes the last line, hence the +1.
        timing_err = (next_vertical_i && hcnt_q != HMAX)
                   || (!next_vertical_i && hcnt_q == HMAX)
                   || (state_q == RUN && next_frame_i && (32'(vcnt_q) + 32'd1) != V_TOT);
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        sig_d       = sig_q;
        sig_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;

        if (state_q != IDLE && timing_err) sync_err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                crc_d = CRC_INIT;
                if (enable_i) begin
                    state_d    = SYNC;
                    sync_err_d = 1'b0;
                end
            end
            SYNC: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    crc_d   = CRC_INIT;
                end else if (next_frame_i) begin
                    state_d = RUN;
                    crc_d   = CRC_INIT;
                end
            end
            RUN: begin
                // A frame boundary delivers even if enable drops in the same cycle.
                if (next_frame_i) begin
                    sig_d       = crc_q;
                    sig_valid_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    crc_d       = CRC_INIT;
                    if (!enable_i) state_d = IDLE;
                end else if (!enable_i) begin
                    state_d = IDLE;
                    crc_d   = CRC_INIT;
                end else if (visible) begin
                    crc_d = crc_absorb6(crc_q, rrggbb_i);
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = CRC_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            crc_q       <= CRC_INIT;
            sig_q       <= 16'h0000;
            sig_valid_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            crc_q       <= crc_d;
            sig_q       <= sig_d;
            sig_valid_q <= sig_valid_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign sig_o       = sig_q;
    assign sig_valid_o = sig_valid_q;
    assign frame_cnt_o = frame_cnt_q;
    assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_frame_signature.sv
// Self-checking bench for frame_signature on a tiny 8x4 raster (4x2 visible).
module tb_frame_signature;

    localparam int W = 4, H = 2, HT = 8, VT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [5:0]  rrggbb_i;
    logic        next_vertical_i;
    logic        next_frame_i;
    logic [15:0] sig_o;
    logic        sig_valid_o;
    logic [7:0]  frame_cnt_o;
    logic        sync_err_o;

    frame_signature #(.WIDTH(W), .HEIGHT(H), .HTOTAL(HT), .VTOTAL(VT), .PIX_OFFSET(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .rrggbb_i(rrggbb_i),
        .next_vertical_i(next_vertical_i), .next_frame_i(next_frame_i),
        .sig_o(sig_o), .sig_valid_o(sig_valid_o), .frame_cnt_o(frame_cnt_o),
        .sync_err_o(sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [5:0]  pix [VT][HT];
    logic [15:0] vq[$];
    logic [7:0]  cq[$];
    int          err_first;
    int          cnt_exp;
    logic [15:0] ref2a;
    logic [15:0] s1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: serialise visible pixels (raster order, MSB first) and run a plain CRC-16/CCITT.
    function automatic logic [15:0] model_crc();
        bit          bits[$];
        logic [15:0] crc = 16'hFFFF;
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                for (int b = 5; b >= 0; b--) bits.push_back(pix[v][h][b]);
        foreach (bits[i]) begin
            if (crc[15] ^ bits[i]) crc = (crc << 1) ^ 16'h1021;
            else                   crc = crc << 1;
        end
        return crc;
    endfunction

    task automatic fill_const(input logic [5:0] val);
        for (int v = 0; v < VT; v++) for (int h = 0; h < HT; h++) pix[v][h] = val;
    endtask

    task automatic fill_rand();
        for (int v = 0; v < VT; v++) for (int h = 0; h < HT; h++) pix[v][h] = 6'($urandom);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".sig"}, 32'(sig_o), 32'h0);
        chk({tag, ".valid"}, 32'(sig_valid_o), 32'h0);
        chk({tag, ".cnt"}, 32'(frame_cnt_o), 32'h0);
        chk({tag, ".err"}, 32'(sync_err_o), 32'h0);
    endtask

    // Drives one frame of nlines lines; called at a negedge, returns at a negedge.
    task automatic drive_frame(input int nlines, input int bad_h, input int drop_at,
                               input int drop_len, input int rst_at);
        int c = 0;
        vq.delete();
        cq.delete();
        err_first = -1;
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (c == rst_at) begin
                    rst_ni = 1'b0;
                    #1;
                    chk_reset_outputs("async_rst");
                    return;
                end
                enable_i        = !(c >= drop_at && c < drop_at + drop_len);
                rrggbb_i        = pix[v][h];
                next_vertical_i = (h == HT - 1) || (v == 0 && h == bad_h);
                next_frame_i    = (h == HT - 1) && (v == nlines - 1);
                @(negedge clk_i);
                if (sig_valid_o) begin
                    vq.push_back(sig_o);
                    cq.push_back(frame_cnt_o);
                end
                if (sync_err_o && err_first < 0) err_first = c;
                c++;
            end
        end
    endtask

    task automatic expect_sig(input string tag, input bit want);
        chk({tag, ".nvalid"}, 32'(vq.size()), want ? 32'd1 : 32'd0);
        if (want) begin
            cnt_exp = (cnt_exp + 1) & 255;
            if (vq.size() > 0) begin
                chk({tag, ".sig"}, 32'(vq[0]), 32'(model_crc()));
                chk({tag, ".cnt"}, 32'(cq[0]), 32'(cnt_exp));
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; rrggbb_i = '0;
        next_vertical_i = 1'b0; next_frame_i = 1'b0;
        cnt_exp = 0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_ni = 1'b1;

        fill_const(6'h2A);
        ref2a = model_crc();
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("sync_frame", 0);
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("frame2", 1);
        s1 = (vq.size() > 0) ? vq[0] : 16'h0;
        chk("frame2.ref", 32'(s1), 32'(ref2a));
        chk("frame2.err", 32'(sync_err_o), 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive_frame(VT, -1, 0, 0, -1);
            expect_sig("repeat", 1);
            if (vq.size() > 0) chk("repeat.equal", 32'(vq[0]), 32'(s1));
        end

        pix[1][2] = 6'h2B;
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("vis_change", 1);
        if (vq.size() > 0) chk("vis_change.differs", 32'(vq[0] != ref2a), 32'h1);
        fill_const(6'h2A);
        pix[0][5] = 6'h15;
        pix[2][1] = 6'h3F;
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("blank_change", 1);
        if (vq.size() > 0) chk("blank_change.same", 32'(vq[0]), 32'(ref2a));

        for (int i = 0; i < 3; i++) begin
            fill_rand();
            drive_frame(VT, -1, 0, 0, -1);
            expect_sig("rand", 1);
        end

        fill_rand();
        drive_frame(VT, 6, 0, 0, -1);
        chk("early_nv.err_cycle", 32'(err_first), 32'd6);
        chk("early_nv.captured", 32'(vq.size()), 32'd1);
        cnt_exp = (cnt_exp + 1) & 255;
        if (cq.size() > 0) chk("early_nv.cnt", 32'(cq[0]), 32'(cnt_exp));
        fill_rand();
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("after_err", 1);
        chk("err.sticky", 32'(sync_err_o), 32'h1);

        fill_rand();
        drive_frame(VT, -1, 10, 3, -1);
        expect_sig("enable_drop", 0);
        chk("enable_drop.err_clear", 32'(sync_err_o), 32'h0);
        fill_rand();
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("after_drop", 1);

        fill_rand();
        drive_frame(VT - 1, -1, 0, 0, -1);
        expect_sig("short_frame", 1);
        chk("short_frame.err", 32'(sync_err_o), 32'h1);

        fill_rand();
        drive_frame(VT, -1, VT * HT - 1, 1, -1);
        expect_sig("drop_at_frame", 1);
        fill_rand();
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("resync", 0);
        chk("resync.err_clear", 32'(sync_err_o), 32'h0);
        fill_rand();
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("resync_run", 1);

        fill_rand();
        drive_frame(VT, -1, 0, 0, 12);
        cnt_exp = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        fill_const(6'h2A);
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("post_rst_sync", 0);
        drive_frame(VT, -1, 0, 0, -1);
        expect_sig("post_rst", 1);
        if (vq.size() > 0) chk("post_rst.ref", 32'(vq[0]), 32'(ref2a));

        for (int i = 0; i < 258; i++) begin
            fill_rand();
            drive_frame(VT, -1, 0, 0, -1);
            expect_sig("wrap", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
